// File: rtl/truth_table_scanner.sv
// Truth-table scanner for a 3-input combinational function.
// Steps the drive lines through vectors 0..7. Each vector is held for
// SETTLE_CYCLES wait cycles plus one sample cycle. The scanner then
// captures fOut per vector and compares the captured table with an
// expected table that is latched when the scan starts.
// o_table carries the captured truth table (bit i = fOut for vector i).
module truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expTable,
    input  logic       fOut,
    output logic       drvX,
    output logic       drvY,
    output logic       drvZ,
    output logic       busy,
    output logic       done,
    output logic       match,
    output logic [7:0] o_table,
    output logic [7:0] mismatch
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_idx;
    logic [2:0] w_next_idx;
    logic [7:0] r_cnt;
    logic [7:0] r_table;
    logic [7:0] w_table_next;
    logic [7:0] r_exp;
    logic       r_match;
    logic [7:0] r_mismatch;
    logic [2:0] r_drv;
    logic [2:0] w_drv_next;
    logic       r_busy;
    logic       r_done;

    // Next-state, next-index, next-table and next drive-vector decode.
    always_comb begin
        w_next_state         = r_state;
        w_next_idx           = r_idx;
        w_table_next         = r_table;
        w_table_next[r_idx]  = fOut;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_WAIT;
                    w_next_idx   = 3'd0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_next_state = S_SAMPLE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_SAMPLE: begin
                if (r_idx == 3'd7) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT;
                    w_next_idx   = r_idx + 3'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if ((w_next_state == S_WAIT) || (w_next_state == S_SAMPLE)) begin
            w_drv_next = w_next_idx;
        end else begin
            w_drv_next = 3'd0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Scan datapath: index, settle counter, captured table and comparison results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= 3'd0;
            r_cnt      <= 8'd0;
            r_table    <= 8'd0;
            r_exp      <= 8'd0;
            r_match    <= 1'b0;
            r_mismatch <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= 3'd0;
                        r_cnt      <= 8'd0;
                        r_table    <= 8'd0;
                        r_exp      <= expTable;
                        r_match    <= 1'b0;
                        r_mismatch <= 8'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                end
                S_SAMPLE: begin
                    r_table <= w_table_next;
                    r_idx   <= w_next_idx;
                    r_cnt   <= 8'd0;
                    if (r_idx == 3'd7) begin
                        r_match    <= (w_table_next == r_exp);
                        r_mismatch <= w_table_next ^ r_exp;
                    end
                end
                S_DONE: begin
                    r_cnt <= 8'd0;
                end
                default: begin
                    r_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Registered status and drive outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_drv  <= 3'd0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (w_next_state == S_DONE);
            r_drv  <= w_drv_next;
        end
    end

    assign drvX     = r_drv[0];
    assign drvY     = r_drv[1];
    assign drvZ     = r_drv[2];
    assign busy     = r_busy;
    assign done     = r_done;
    assign match    = r_match;
    assign o_table  = r_table;
    assign mismatch = r_mismatch;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: vector table, random functions
// against a behavioural model, and hand-written multi-cycle corner sequences.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // DUT with SETTLE_CYCLES=4
    logic       start4;
    logic [7:0] exp4;
    logic       fOut4;
    logic       drvX4, drvY4, drvZ4, busy4, done4, match4;
    logic [7:0] table4, mis4;
    logic       use_cons;
    logic [7:0] rand_tt4;

    // DUT with SETTLE_CYCLES=1
    logic       start1;
    logic [7:0] exp1;
    logic       fOut1;
    logic       drvX1, drvY1, drvZ1, busy1, done1, match1;
    logic [7:0] table1, mis1;
    logic [7:0] f1_tt;

    // Views of whichever DUT the current scan task targets
    bit         sel_g;
    logic       v_done, v_busy, v_match;
    logic [2:0] v_drv;
    logic [7:0] v_table, v_mis;

    always #5 clk = ~clk;

    assign fOut4 = use_cons ? ((drvX4 | drvY4) & (~drvX4 | drvZ4) & (drvY4 | drvZ4))
                            : rand_tt4[{drvZ4, drvY4, drvX4}];
    assign fOut1 = f1_tt[{drvZ1, drvY1, drvX1}];

    assign v_done  = sel_g ? done1  : done4;
    assign v_busy  = sel_g ? busy1  : busy4;
    assign v_match = sel_g ? match1 : match4;
    assign v_drv   = sel_g ? {drvZ1, drvY1, drvX1} : {drvZ4, drvY4, drvX4};
    assign v_table = sel_g ? table1 : table4;
    assign v_mis   = sel_g ? mis1   : mis4;

    truth_table_scanner #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .expTable(exp4), .fOut(fOut4),
        .drvX(drvX4), .drvY(drvY4), .drvZ(drvZ4), .busy(busy4), .done(done4),
        .match(match4), .o_table(table4), .mismatch(mis4)
    );

    truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expTable(exp1), .fOut(fOut1),
        .drvX(drvX1), .drvY(drvY1), .drvZ(drvZ1), .busy(busy1), .done(done1),
        .match(match1), .o_table(table1), .mismatch(mis1)
    );

    typedef struct {
        bit         cons;
        logic [7:0] func;
        logic [7:0] exp_in;
        logic [7:0] e_table;
        logic       e_match;
        logic [7:0] e_mis;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: truth table of the function evaluated vector by vector
    function automatic logic [7:0] model_table(input bit cons, input logic [7:0] tt);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            int x = i % 2;
            int y = (i / 2) % 2;
            int z = i / 4;
            if (cons) r[i] = ((x + y) > 0) && (((1 - x) + z) > 0) && ((y + z) > 0);
            else      r[i] = tt[i];
        end
        return r;
    endfunction

    task automatic run_scan(input bit sel, input logic [7:0] exp_v, input int disturb_n,
                            input int abort_n, output bit completed);
        int per;
        int total;
        int n;
        per       = sel ? 2 : 5;
        total     = 8 * per;
        completed = 1'b0;
        sel_g     = sel;
        @(negedge clk);
        if (sel) begin exp1 = exp_v; start1 = 1'b1; end
        else     begin exp4 = exp_v; start4 = 1'b1; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        n = 0;
        chk("busy_accept", v_busy, 1);
        chk("drv_first", v_drv, 0);
        while ((n < total + 20) && !completed) begin
            if (n == disturb_n) begin start4 = 1'b1; exp4 = 8'h00; end
            if (n == disturb_n + 2) start4 = 1'b0;
            if (n == abort_n) rst = 1'b1;
            @(posedge clk); n++; #1;
            if ((abort_n >= 0) && (n == abort_n + 1)) begin
                rst = 1'b0;
                chk("abort_busy", v_busy, 0);
                chk("abort_done", v_done, 0);
                chk("abort_drv", v_drv, 0);
                chk("abort_table", v_table, 0);
                chk("abort_match", v_match, 0);
                chk("abort_mis", v_mis, 0);
                return;
            end
            if (v_done) begin
                completed = 1'b1;
                chk("latency", n, total);
                chk("drv_done", v_drv, 0);
                chk("busy_done", v_busy, 1);
            end else begin
                chk("busy_scan", v_busy, 1);
                chk("drv_step", v_drv, n / per);
            end
        end
        if (!completed) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout actual=no_done required=done_within_%0d", total + 20);
        end else begin
            @(posedge clk); #1;
            chk("done_pulse", v_done, 0);
            chk("busy_idle", v_busy, 0);
        end
    endtask

    initial begin
        bit         ok;
        bit         seen;
        logic [7:0] e_tab;
        logic [7:0] ex;

        vecs[0] = '{cons: 1'b1, func: 8'h00, exp_in: 8'hE4, e_table: 8'hE4, e_match: 1'b1, e_mis: 8'h00};
        vecs[1] = '{cons: 1'b1, func: 8'h00, exp_in: 8'hEC, e_table: 8'hE4, e_match: 1'b0, e_mis: 8'h08};
        vecs[2] = '{cons: 1'b0, func: 8'h00, exp_in: 8'hFF, e_table: 8'h00, e_match: 1'b0, e_mis: 8'hFF};
        vecs[3] = '{cons: 1'b0, func: 8'h5A, exp_in: 8'h5A, e_table: 8'h5A, e_match: 1'b1, e_mis: 8'h00};

        // Reset held two cycles with start asserted
        rst = 1'b1; start4 = 1'b1; start1 = 1'b1; exp4 = 8'hFF; exp1 = 8'hFF;
        use_cons = 1'b1; rand_tt4 = 8'h00; f1_tt = 8'hFF; sel_g = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_match", match4, 0);
        chk("rst_table", table4, 0);
        chk("rst_mis", mis4, 0);
        chk("rst_drv", {drvZ4, drvY4, drvX4}, 0);
        chk("rst_busy1", busy1, 0);
        @(negedge clk);
        rst = 1'b0; start4 = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        chk("rst_idle", busy4, 0);

        // Table-driven vectors
        for (int k = 0; k < 4; k++) begin
            use_cons = vecs[k].cons;
            rand_tt4 = vecs[k].func;
            run_scan(1'b0, vecs[k].exp_in, -1, -1, ok);
            chk("vec_table", table4, vecs[k].e_table);
            chk("vec_match", match4, vecs[k].e_match);
            chk("vec_mis", mis4, vecs[k].e_mis);
            repeat (3) @(posedge clk);
            #1;
            chk("vec_hold", table4, vecs[k].e_table);
        end

        // Random functions and expected tables against the model
        for (int k = 0; k < 10; k++) begin
            use_cons = (k % 4) == 0;
            rand_tt4 = 8'($urandom);
            e_tab = model_table(use_cons, rand_tt4);
            ex = ($urandom_range(0, 1) == 1) ? e_tab : 8'($urandom);
            run_scan(1'b0, ex, -1, -1, ok);
            chk("rnd_table", table4, e_tab);
            chk("rnd_match", match4, e_tab == ex);
            chk("rnd_mis", mis4, e_tab ^ ex);
        end

        // Start re-pulsed and expTable cleared during vector 3
        use_cons = 1'b1;
        run_scan(1'b0, 8'hE4, 16, -1, ok);
        chk("rob_table", table4, 8'hE4);
        chk("rob_match", match4, 1);
        chk("rob_mis", mis4, 8'h00);

        // Reset during vector 3 aborts, then a full scan follows
        run_scan(1'b0, 8'hE4, -1, 16, ok);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done4 || busy4) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        run_scan(1'b0, 8'hE4, -1, -1, ok);
        chk("post_abort_table", table4, 8'hE4);
        chk("post_abort_match", match4, 1);

        // Start held high: new scan on the first IDLE cycle after DONE
        @(negedge clk);
        exp4 = 8'hE4; start4 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk); #1;
            if (done4) seen = 1'b1;
        end
        chk("held_done", seen, 1);
        @(posedge clk); #1;
        chk("held_idle", busy4, 0);
        @(posedge clk); #1;
        chk("held_restart", busy4, 1);
        start4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk); #1;
            if (done4) seen = 1'b1;
        end
        chk("held_done2", seen, 1);
        chk("held_table", table4, 8'hE4);

        // Minimum settle on the SETTLE_CYCLES=1 instance, fOut tied high
        f1_tt = 8'hFF;
        run_scan(1'b1, 8'hFF, -1, -1, ok);
        chk("min_table", table1, 8'hFF);
        chk("min_match", match1, 1);
        chk("min_mis", mis1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
